// File: rtl/digit_serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor: WIDTH bits processed DIGIT per clock
// through a registered inter-digit carry, with start/done handshake and carry/overflow/zero flags.
module digit_serial_add_sub #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             addn_sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int IW   = $clog2(WIDTH);

   generate
      if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
         $error("digit_serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_r;
   state_t           next_state_s;
   logic [WIDTH-1:0] xa_r;
   logic [WIDTH-1:0] yb_r;
   logic [WIDTH-1:0] sum_r;
   logic [WIDTH-1:0] full_s;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;
   logic [IW-1:0]    base_s;
   logic [DIGIT-1:0] dx_s;
   logic [DIGIT-1:0] dy_s;
   logic [DIGIT-1:0] dsum_s;
   logic             dcout_s;
   logic             cmsb_s;
   logic             last_s;
   logic             accept_s;
   logic             finish_s;
   logic             busy_nx_s;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] s_r;
   logic             cout_r;
   logic             ovf_r;
   logic             zero_r;

   // Current digit slice, its sum with the carry register, and the merged full-width result.
   always_comb begin
      base_s = IW'(cnt_r) * IW'(DIGIT);
      dx_s   = xa_r[base_s +: DIGIT];
      dy_s   = yb_r[base_s +: DIGIT];
      {dcout_s, dsum_s} = {1'b0, dx_s} + {1'b0, dy_s} + {{DIGIT{1'b0}}, carry_r};
      // Carry into the top bit of this digit; only meaningful on the final digit.
      cmsb_s = dx_s[DIGIT-1] ^ dy_s[DIGIT-1] ^ dsum_s[DIGIT-1];
      full_s = sum_r;
      full_s[base_s +: DIGIT] = dsum_s;
      last_s = (cnt_r == CW'(NDIG - 1));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = IDLE;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_state_s = RUN;
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = RUN;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // FSM decode: accept strobe, final-digit strobe and next busy value.
   always_comb begin
      accept_s = 1'b0;
      finish_s = 1'b0;
      case (state_r)
         IDLE:    accept_s = start;
         RUN:     finish_s = last_s;
         default: begin
            accept_s = 1'b0;
            finish_s = 1'b0;
         end
      endcase
      busy_nx_s = (next_state_s == RUN);
   end

   // Operand latch, digit iteration and result/flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         xa_r    <= {WIDTH{1'b0}};
         yb_r    <= {WIDTH{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         s_r     <= {WIDTH{1'b0}};
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
         zero_r  <= 1'b0;
      end else begin
         busy_r <= busy_nx_s;
         done_r <= finish_s;
         if (accept_s) begin
            xa_r    <= x;
            yb_r    <= y ^ {WIDTH{addn_sub}};
            carry_r <= addn_sub;
            cnt_r   <= {CW{1'b0}};
         end else if (state_r == RUN) begin
            sum_r   <= full_s;
            carry_r <= dcout_s;
            cnt_r   <= last_s ? {CW{1'b0}} : cnt_r + CW'(1);
            if (finish_s) begin
               s_r    <= full_s;
               cout_r <= dcout_s;
               ovf_r  <= cmsb_s ^ dcout_s;
               zero_r <= (full_s == {WIDTH{1'b0}});
            end
         end
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign s        = s_r;
   assign cout     = cout_r;
   assign overflow = ovf_r;
   assign zero     = zero_r;

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Bench for digit_serial_add_sub: directed handshake cases on a 16/4 instance plus
// random sweeps on 16/16, 16/1 and 8/2 instances, checked against a scoreboard queue.
module tb_digit_serial_add_sub;

   typedef struct packed {
      logic [15:0] s;
      logic        c;
      logic        v;
      logic        z;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  start_v;
   logic [15:0] x_v [4];
   logic [15:0] y_v [4];
   logic [3:0]  sub_v;
   wire  [3:0]  busy_v;
   wire  [3:0]  done_v;
   wire  [15:0] s_v [4];
   wire  [3:0]  cout_v;
   wire  [3:0]  ovf_v;
   wire  [3:0]  zero_v;
   wire  [7:0]  s8;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   ndig_t [4] = '{4, 1, 16, 4};
   int   wid_t  [4] = '{16, 16, 16, 8};
   exp_t sb [$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   digit_serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_d4 (
      .clk(clk), .reset(reset), .start(start_v[0]), .x(x_v[0]), .y(y_v[0]),
      .addn_sub(sub_v[0]), .busy(busy_v[0]), .done(done_v[0]), .s(s_v[0]),
      .cout(cout_v[0]), .overflow(ovf_v[0]), .zero(zero_v[0]));

   digit_serial_add_sub #(.WIDTH(16), .DIGIT(16)) u_d16 (
      .clk(clk), .reset(reset), .start(start_v[1]), .x(x_v[1]), .y(y_v[1]),
      .addn_sub(sub_v[1]), .busy(busy_v[1]), .done(done_v[1]), .s(s_v[1]),
      .cout(cout_v[1]), .overflow(ovf_v[1]), .zero(zero_v[1]));

   digit_serial_add_sub #(.WIDTH(16), .DIGIT(1)) u_d1 (
      .clk(clk), .reset(reset), .start(start_v[2]), .x(x_v[2]), .y(y_v[2]),
      .addn_sub(sub_v[2]), .busy(busy_v[2]), .done(done_v[2]), .s(s_v[2]),
      .cout(cout_v[2]), .overflow(ovf_v[2]), .zero(zero_v[2]));

   digit_serial_add_sub #(.WIDTH(8), .DIGIT(2)) u_w8 (
      .clk(clk), .reset(reset), .start(start_v[3]), .x(x_v[3][7:0]), .y(y_v[3][7:0]),
      .addn_sub(sub_v[3]), .busy(busy_v[3]), .done(done_v[3]), .s(s8),
      .cout(cout_v[3]), .overflow(ovf_v[3]), .zero(zero_v[3]));

   assign s_v[3] = {8'h00, s8};

   // Reference: plain wide sum for result/carry, sign rule for signed overflow.
   function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic sub);
      exp_t        r;
      logic [16:0] full;
      logic [15:0] m;
      logic [15:0] am;
      logic [15:0] bb;
      logic        sa;
      logic        sbit;
      logic        ss;
      m    = (w == 16) ? 16'hFFFF : 16'h00FF;
      am   = a & m;
      bb   = (sub ? ~b : b) & m;
      full = {1'b0, am} + {1'b0, bb} + {16'h0000, sub};
      r.s  = full[15:0] & m;
      r.c  = (w == 16) ? full[16] : full[8];
      sa   = a[w-1];
      sbit = b[w-1];
      ss   = r.s[w-1];
      r.v  = sub ? ((sa != sbit) && (ss != sa)) : ((sa == sbit) && (ss != sa));
      r.z  = (r.s == 16'h0000);
      return r;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; start is seen by the next posedge.
   task automatic launch(int i, logic [15:0] a, logic [15:0] b, logic sub, bit push);
      x_v[i]     = a;
      y_v[i]     = b;
      sub_v[i]   = sub;
      start_v[i] = 1'b1;
      if (push) sb.push_back(model(wid_t[i], a, b, sub));
      acc_cyc = cyc + 1;
      @(negedge clk);
      start_v[i] = 1'b0;
   endtask

   task automatic wait_done(int i, string tag);
      int   n;
      bit   busy_ok;
      exp_t e;
      n = 0;
      busy_ok = 1'b1;
      while (done_v[i] !== 1'b1 && n < 64) begin
         if (busy_v[i] !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, {31'd0, done_v[i]}, 32'd1);
      check({tag, "_latency"}, cyc - acc_cyc, ndig_t[i]);
      check({tag, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
      check({tag, "_busy_done"}, {31'd0, busy_v[i]}, 32'd0);
      check({tag, "_sb_depth"}, sb.size(), 32'd1);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      check({tag, "_s"}, {16'h0000, s_v[i]}, {16'h0000, e.s});
      check({tag, "_cout"}, {31'd0, cout_v[i]}, {31'd0, e.c});
      check({tag, "_ovf"}, {31'd0, ovf_v[i]}, {31'd0, e.v});
      check({tag, "_zero"}, {31'd0, zero_v[i]}, {31'd0, e.z});
   endtask

   task automatic no_done(int i, int ncyc, string tag);
      int cnt;
      cnt = 0;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         if (done_v[i] === 1'b1) cnt++;
      end
      check(tag, cnt, 32'd0);
   endtask

   initial begin
      start_v = 4'h0;
      sub_v   = 4'h0;
      for (int i = 0; i < 4; i++) begin
         x_v[i] = 16'h0000;
         y_v[i] = 16'h0000;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("rst_busy", {28'd0, busy_v}, 32'd0);
      check("rst_done", {28'd0, done_v}, 32'd0);
      check("rst_s", {16'h0000, s_v[0]}, 32'd0);
      check("rst_flags", {29'd0, cout_v[0], ovf_v[0], zero_v[0]}, 32'd0);

      launch(0, 16'h1234, 16'h0FED, 1'b0, 1'b1);
      wait_done(0, "add_basic");
      @(negedge clk);
      check("done_one_cycle", {31'd0, done_v[0]}, 32'd0);
      check("hold_s", {16'h0000, s_v[0]}, 32'h2221);

      launch(0, 16'h0005, 16'h0005, 1'b1, 1'b1);
      wait_done(0, "sub_zero");
      launch(0, 16'h0000, 16'h0001, 1'b1, 1'b1);
      wait_done(0, "sub_borrow");
      launch(0, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
      wait_done(0, "add_ovf");
      launch(0, 16'h8000, 16'h0001, 1'b1, 1'b1);
      wait_done(0, "sub_ovf");

      // Second start two cycles after accept, with x changed mid-operation.
      launch(0, 16'h1234, 16'h0FED, 1'b0, 1'b1);
      @(negedge clk);
      x_v[0]     = 16'hAAAA;
      y_v[0]     = 16'h5555;
      sub_v[0]   = 1'b1;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_done(0, "ignored_start");
      no_done(0, 8, "ignored_no_extra_done");

      // Start presented in the done cycle is accepted.
      launch(0, 16'h1234, 16'h0FED, 1'b0, 1'b1);
      wait_done(0, "b2b_first");
      launch(0, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
      wait_done(0, "b2b_second");

      // Reset two cycles after accept aborts the operation.
      launch(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", {31'd0, busy_v[0]}, 32'd0);
      check("abort_done", {31'd0, done_v[0]}, 32'd0);
      check("abort_s", {16'h0000, s_v[0]}, 32'd0);
      check("abort_flags", {29'd0, cout_v[0], ovf_v[0], zero_v[0]}, 32'd0);
      no_done(0, 8, "abort_no_done");
      launch(0, 16'h1234, 16'h0FED, 1'b0, 1'b1);
      wait_done(0, "after_abort");

      // Random sweeps, back-to-back, on the other parameterisations.
      for (int i = 1; i < 4; i++) begin
         for (int n = 0; n < 12; n++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom);
            b = 16'($urandom);
            if (n == 0) begin
               a = 16'hFFFF;
               b = 16'h0001;
            end
            if (wid_t[i] == 8) begin
               a = a & 16'h00FF;
               b = b & 16'h00FF;
            end
            launch(i, a, b, 1'($urandom_range(0, 1)), 1'b1);
            wait_done(i, $sformatf("sweep%0d_%0d", i, n));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/digit_serial_add_sub.md
Name: digit_serial_add_sub

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor. Successor to the fixed 4-bit combinational adder/subtractor.
- Processes a WIDTH-bit operation DIGIT bits per clock, using a registered inter-digit carry. This trades latency for a narrow carry chain.
- Start/done handshake; adds unsigned-carry, signed-overflow and zero flags.
- Used wherever a wide add/subtract is needed and timing or area rules out a full-width ripple chain.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >= 2.
- DIGIT, 4, bits processed per cycle.
  - 1 <= DIGIT <= WIDTH.
  - WIDTH % DIGIT == 0; violation is an elaboration error.
- Derived: NDIG = WIDTH/DIGIT (cycles per operation).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- addn_sub  in  1  0 = x+y, 1 = x-y (computed as x + ~y + 1)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result valid
- s  out  WIDTH  result
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow (x >= y unsigned)
- overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB
- zero  out  1  s == 0

Behaviour:
- Reset (sync, highest priority): state=IDLE; busy, done, s, cout, overflow, zero all 0; internal operand, partial-sum, carry and digit counter cleared. Reset mid-operation aborts it; no done is produced.
- FSM states: IDLE, RUN.
- IDLE, start=1 at edge E0:
  - Latch x, y^{WIDTH{addn_sub}} and addn_sub.
  - Carry reg <= addn_sub; digit counter <= 0; go to RUN; busy=1 from E0.
- IDLE, start=0: hold; done deasserts after one cycle.
- RUN, edge E(k+1), k=0..NDIG-1:
  - Add digit k (bits k*DIGIT+DIGIT-1 : k*DIGIT) of latched x and latched inverted y, plus carry reg.
  - Write digit k of the internal result; carry reg <= digit carry out; counter++.
- Final digit (k=NDIG-1), edge E(NDIG):
  - Load s with the full result; load cout and overflow; load zero from the full result.
  - done=1, busy=0, state -> IDLE.
- Latency: exactly NDIG cycles from the accepting edge to the done cycle. DIGIT=WIDTH gives 1 cycle.
- Overflow uses the carry into bit WIDTH-1. When DIGIT=1 this is the carry reg value entering the last digit.
- done is high for exactly one cycle.
- start sampled in the done cycle (state IDLE) is accepted: back-to-back throughput is one op per NDIG cycles.
- start while busy=1 is ignored (no queueing).
- x, y and addn_sub changes after acceptance have no effect on the result in progress.
- s/cout/overflow/zero hold the last completed result until the next done. They never show partial values.
- All arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=16, DIGIT=4, add 0x1234+0x0FED, start one cycle → busy 4 cycles; done on 4th cycle after accept; s=0x2221, cout=0, overflow=0, zero=0.
- Subtract 0x0005-0x0005 → s=0x0000, cout=1, overflow=0, zero=1. Subtract 0x0000-0x0001 → s=0xFFFF, cout=0, overflow=0.
- Signed overflow: add 0x7FFF+0x0001 → s=0x8000, overflow=1, cout=0. Subtract 0x8000-0x0001 → s=0x7FFF, overflow=1, cout=1.
- Handshake:
  - Pulse start again 2 cycles after accept, with different operands → ignored; first result unchanged.
  - Change x mid-operation → no effect.
  - Assert start in the done cycle with 0xFFFF+0x0001 → accepted; 4 cycles later s=0x0000, cout=1, zero=1.
- Reset mid-operation: assert reset 2 cycles after accept → next cycle all outputs 0, busy=0; no done pulse follows. A new start afterwards completes normally.
- Parameter sweep with random operands vs a reference model, all flags checked:
  - DIGIT=16 (latency 1).
  - DIGIT=1 (latency 16).
  - WIDTH=8, DIGIT=2 (latency 4).
